// File: rtl/vga_timing_gen.sv
// VGA 640x480@60 raster timing generator.
// Divides the system clock by two and decodes syncs from the pixel counters.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clock_50M,
  input  logic       reset,
  output logic       clock_25M,
  output logic [9:0] sx,
  output logic [9:0] sy,
  output logic       hsync,
  output logic       vsync,
  output logic       de
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic step;

  // Pixel steps happen on the edge where the divided clock rises.
  assign step = ~clock_25M;

  // Divide-by-two pixel clock.
  always_ff @(posedge clock_50M) begin
    if (reset) begin
      clock_25M <= 1'b0;
    end else begin
      clock_25M <= ~clock_25M;
    end
  end

  // Raster counters; sy advances when sx wraps.
  always_ff @(posedge clock_50M) begin
    if (reset) begin
      sx <= '0;
      sy <= '0;
    end else if (step) begin
      if (sx == H_LAST) begin
        sx <= '0;
        if (sy == V_LAST) begin
          sy <= '0;
        end else begin
          sy <= sy + 10'd1;
        end
      end else begin
        sx <= sx + 10'd1;
      end
    end
  end

  // Sync and enable decoded straight from the registered counters.
  always_comb begin
    hsync = ~((sx >= HS_START) && (sx <= HS_END));
    vsync = ~((sy >= VS_START) && (sy <= VS_END));
    de    = (sx < H_VIS) && (sy < V_VIS);
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: full horizontal timing,
// shortened vertical timing (15 lines) so whole frames fit in the run.
module tb_vga_timing_gen;

  localparam int VT    = 15;
  localparam int FRAME = 800 * VT;

  typedef struct packed {
    logic       c;
    logic [9:0] x;
    logic [9:0] y;
    logic       h;
    logic       v;
    logic       d;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       clock_25M;
  logic [9:0] sx;
  logic [9:0] sy;
  logic       hsync;
  logic       vsync;
  logic       de;

  int checks = 0;
  int errors = 0;

  exp_t q[$];
  int   n = 0;
  bit   in_win = 0;

  int cyc = 0;
  int de_cnt = 0;
  int hs_cnt = 0;
  int vs_cnt = 0;
  int vb_cnt = 0;
  int fr_cnt = 0;
  int fr_first = -1;
  int fr_last = -1;

  vga_timing_gen #(
    .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
    .V_ACTIVE(8),   .V_FP(2),  .V_SYNC(2),  .V_BP(3)
  ) dut (
    .clock_50M(clk),
    .reset(reset),
    .clock_25M(clock_25M),
    .sx(sx),
    .sy(sy),
    .hsync(hsync),
    .vsync(vsync),
    .de(de)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input int cnt);
    exp_t e;
    int   steps;
    int   pos;
    steps = (cnt + 1) / 2;
    pos   = steps % FRAME;
    e.c = (cnt % 2) == 1;
    e.x = 10'(pos % 800);
    e.y = 10'(pos / 800);
    e.h = !(e.x >= 656 && e.x <= 751);
    e.v = !(e.y >= 10 && e.y <= 11);
    e.d = (e.x < 640) && (e.y < 8);
    return e;
  endfunction

  task automatic cyc_step(input bit r);
    exp_t e;
    @(negedge clk);
    reset = r;
    if (r) begin
      n = 0;
      e = '{c: 1'b0, x: 10'd0, y: 10'd0, h: 1'b1, v: 1'b1, d: 1'b1};
    end else begin
      n++;
      e = model(n);
    end
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  // Monitor: pop one expected bundle per clock and compare.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (clock_25M !== e.c || sx !== e.x || sy !== e.y ||
          hsync !== e.h || vsync !== e.v || de !== e.d) begin
        errors++;
        $display("FAIL cycle n=%0d: got c=%b sx=%0d sy=%0d h=%b v=%b de=%b expected c=%b sx=%0d sy=%0d h=%b v=%b de=%b",
                 n, clock_25M, sx, sy, hsync, vsync, de,
                 e.c, e.x, e.y, e.h, e.v, e.d);
      end
    end
    if (in_win) begin
      cyc++;
      if (!hsync) hs_cnt++;
      if (!vsync) vs_cnt++;
      if (clock_25M && de) de_cnt++;
      if (clock_25M && sx == 10'd0 && sy == 10'd8) vb_cnt++;
      if (clock_25M && sx == 10'd0 && sy == 10'd0) begin
        fr_cnt++;
        if (fr_first < 0) fr_first = cyc;
        fr_last = cyc;
      end
    end
  end

  initial begin
    repeat (3) cyc_step(1'b1);

    // Directed start-up sequence: clock_25M 1,0,1,0 and sx 1,1,2,2,3.
    begin
      int ex_sx[5] = '{1, 1, 2, 2, 3};
      int ex_c[5]  = '{1, 0, 1, 0, 1};
      for (int i = 0; i < 5; i++) begin
        cyc_step(1'b0);
        @(posedge clk);
        #2;
        chk("startup sx", int'(sx), ex_sx[i]);
        chk("startup clock_25M", int'(clock_25M), ex_c[i]);
        chk("startup sy", int'(sy), 0);
      end
    end

    // Re-reset, then two complete frames with aggregate counters.
    cyc_step(1'b1);
    @(negedge clk);
    in_win = 1;
    reset = 1'b0;
    n = 1;
    q.push_back(model(1));
    for (int i = 1; i < 2 * FRAME * 2; i++) cyc_step(1'b0);
    @(negedge clk);
    in_win = 0;
    reset = 1'b0;
    n++;
    q.push_back(model(n));

    chk("de pixel count", de_cnt, 2 * 640 * 8);
    chk("hsync low cycles", hs_cnt, 2 * VT * 192);
    chk("vsync low cycles", vs_cnt, 2 * 2 * 1600);
    chk("vblank start count", vb_cnt, 2);
    chk("frame start count", fr_cnt, 2);
    chk("frame length", fr_last - fr_first, 2 * FRAME);

    // Mid-frame reset at sx=700, sy=10.
    cyc_step(1'b1);
    for (int i = 0; i < 2 * (10 * 800 + 700) - 1; i++) cyc_step(1'b0);
    @(posedge clk);
    #2;
    chk("pre-reset sx", int'(sx), 700);
    chk("pre-reset sy", int'(sy), 10);
    cyc_step(1'b1);
    @(posedge clk);
    #2;
    chk("reset sx", int'(sx), 0);
    chk("reset sy", int'(sy), 0);
    chk("reset clock_25M", int'(clock_25M), 0);
    chk("reset hsync", int'(hsync), 1);
    chk("reset vsync", int'(vsync), 1);
    for (int i = 0; i < 4; i++) cyc_step(1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
